// File: rtl/exam1_sched_pkg.sv
// exam1_sched_pkg: opcodes, FSM state encoding and default operand width
// shared by the op scheduler and its shift-add multiplier.
package exam1_sched_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exam1_op_scheduler_shift_add_mul.sv
// shift_add_mul: WIDTH-cycle unsigned multiplier, one multiplier bit per cycle LSB first.
// product is valid combinationally during the cycle where done is high.
module shift_add_mul
  import exam1_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SW-1:0]      r_step;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_accNext;

  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign w_accNext = r_acc + w_partial;
  assign done      = r_busy && (r_step == SW'(WIDTH - 1));
  assign product   = w_accNext;

  // The final step's sum is exposed directly so the caller can capture it on the done edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_step   <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_step   <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_step   <= r_step + SW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exam1_op_scheduler.sv
// exam1_op_scheduler: two requesters share one ADD/SUB/MUL/MAX engine behind a valid/ready result port.
// Define SCHED_FIXED_PRIO_EN for fixed priority (req0 wins ties); otherwise arbitration is round-robin.
module exam1_op_scheduler
  import exam1_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [1:0]         req0_ctrl,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [1:0]         req1_ctrl,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_ctrl;
  logic               r_id;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_respOut;
  logic               r_respId;
`ifndef SCHED_FIXED_PRIO_EN
  logic               r_lastGrant;
`endif

  logic               w_grantId;
  logic               w_accept;
  logic [WIDTH-1:0]   w_selA;
  logic [WIDTH-1:0]   w_selB;
  logic [1:0]         w_selCtrl;
  logic               w_mulStart;
  logic               w_mulDone;
  logic [2*WIDTH-1:0] w_mulProduct;
  logic               w_execLast;
  logic [2*WIDTH-1:0] w_result;

  always_comb begin
    w_grantId = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef SCHED_FIXED_PRIO_EN
      w_grantId = 1'b0;
`else
      w_grantId = ~r_lastGrant;
`endif
    end else if (req1_valid) begin
      w_grantId = 1'b1;
    end
  end

  // Readys are gated by rst so nothing is accepted while reset is held.
  assign w_accept   = (r_state == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grantId;
  assign req1_ready = w_accept && w_grantId;

  assign w_selA     = w_grantId ? req1_a : req0_a;
  assign w_selB     = w_grantId ? req1_b : req0_b;
  assign w_selCtrl  = w_grantId ? req1_ctrl : req0_ctrl;
  assign w_mulStart = w_accept && (w_selCtrl == OP_MUL);

  shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mulStart),
    .a       (w_selA),
    .b       (w_selB),
    .done    (w_mulDone),
    .product (w_mulProduct)
  );

  assign w_execLast = (r_state == EXEC) && (r_cnt == '0) &&
                      ((r_ctrl != OP_MUL) || w_mulDone);

  always_comb begin
    w_result = '0;
    case (r_ctrl)
      OP_ADD:  w_result = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
      OP_SUB:  w_result = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};
      OP_MUL:  w_result = w_mulProduct;
      default: w_result = {{WIDTH{1'b0}}, (r_a > r_b) ? r_a : r_b};
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = EXEC;
      EXEC:    if (w_execLast) w_nextState = DONE;
      DONE:    if (resp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operands are captured at accept so later port activity cannot disturb the op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= OP_ADD;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_respOut   <= '0;
      r_respId    <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
      r_lastGrant <= 1'b1;
`endif
    end else if (w_accept) begin
      r_a         <= w_selA;
      r_b         <= w_selB;
      r_ctrl      <= w_selCtrl;
      r_id        <= w_grantId;
      r_cnt       <= (w_selCtrl == OP_MUL) ? CW'(WIDTH - 1) : '0;
`ifndef SCHED_FIXED_PRIO_EN
      r_lastGrant <= w_grantId;
`endif
    end else if (r_state == EXEC) begin
      if (w_execLast) begin
        r_respOut <= w_result;
        r_respId  <= r_id;
      end else begin
        r_cnt     <= r_cnt - CW'(1);
      end
    end
  end

  assign resp_valid = (r_state == DONE);
  assign resp_out   = r_respOut;
  assign resp_id    = r_respId;

endmodule

// File: tb/tb_exam1_op_scheduler.sv
// tb_exam1_op_scheduler: randomized scoreboard bench for exam1_op_scheduler.
// A transaction-level model predicts grants, results and result timing; a monitor checks the result port.
module tb_exam1_op_scheduler;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   ctrl;
  } op_t;

  typedef struct packed {
    logic          id;
    logic [RW-1:0] res;
    int            due;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_a, req0_b;
  logic [1:0]    req0_ctrl;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_a, req1_b;
  logic [1:0]    req1_ctrl;
  logic          resp_valid, resp_ready, resp_id;
  logic [RW-1:0] resp_out;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   grantLog[$];
  int   edgeCnt   = 0;
  int   checks    = 0;
  int   failures  = 0;
  int   readyPct  = 100;
  int   mDue      = 0;
  int   mFreeFrom = 0;
  bit   mBusy     = 1'b0;
  bit   lastGrant = 1'b1;
  bit   drv0      = 1'b0;
  bit   drv1      = 1'b0;

  exam1_op_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Reference result straight from the opcode definitions, using plain integer arithmetic.
  function automatic logic [RW-1:0] refResult(input op_t op);
    int unsigned ua, ub;
    ua = op.a;
    ub = op.b;
    case (op.ctrl)
      2'b00:   return RW'(ua + ub);
      2'b01:   return RW'(ua - ub);
      2'b10:   return RW'(ua * ub);
      default: return RW'((ua > ub) ? ua : ub);
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, edgeCnt);
    end
  endtask

  // Drive each requester from the head of its pending queue; idle ports carry random junk.
  task automatic applyStimulus();
    drv0 = (q0.size() > 0);
    drv1 = (q1.size() > 0);
    req0_valid = drv0;
    req1_valid = drv1;
    if (drv0) begin
      req0_a = q0[0].a; req0_b = q0[0].b; req0_ctrl = q0[0].ctrl;
    end else begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_ctrl = 2'($urandom);
    end
    if (drv1) begin
      req1_a = q1[0].a; req1_b = q1[0].b; req1_ctrl = q1[0].ctrl;
    end else begin
      req1_a = W'($urandom); req1_b = W'($urandom); req1_ctrl = 2'($urandom);
    end
    resp_ready = (int'($urandom_range(99)) < readyPct);
  endtask

  // Predict the grant for the coming edge and, on accept, push the expected response.
  task automatic checkOutput();
    logic [1:0] expReady;
    logic       g;
    op_t        op;
    int         lat;
    expReady = 2'b00;
    g = 1'b0;
    if (mBusy) begin
      if (edgeCnt >= mDue && resp_ready) begin
        mBusy = 1'b0;
        mFreeFrom = edgeCnt + 2;
      end
    end else if (edgeCnt + 1 >= mFreeFrom && (drv0 || drv1)) begin
      if (drv0 && drv1) begin
`ifdef SCHED_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~lastGrant;
`endif
      end else begin
        g = drv1;
      end
      expReady = g ? 2'b10 : 2'b01;
    end
    checkVal("req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, expReady});
    if (req0_ready) grantLog.push_back(0);
    else if (req1_ready) grantLog.push_back(1);
    if (expReady != 2'b00) begin
      op = g ? q1.pop_front() : q0.pop_front();
      lat = (op.ctrl == 2'b10) ? W : 1;
      sb.push_back('{id: g, res: refResult(op), due: edgeCnt + 1 + lat});
      lastGrant = g;
      mBusy = 1'b1;
      mDue = edgeCnt + 1 + lat;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    sb.delete();
    grantLog.delete();
    mBusy = 1'b0;
    lastGrant = 1'b1;
    applyStimulus();
    repeat (cycles) begin
      @(negedge clk);
      checkVal("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      checkVal("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkVal("rst_resp_out", {16'd0, resp_out}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mFreeFrom = edgeCnt + 1;
    applyStimulus();
  endtask

  task automatic drain(input int maxCycles, input string tag);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || mBusy) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkVal({tag, "_drained"}, {31'd0, n < maxCycles}, 32'd1);
  endtask

  // Monitor: result port must match the head of the scoreboard exactly when it is due.
  always @(negedge clk) begin : monitor
    logic expValid;
    if (rst === 1'b0) begin
      expValid = (sb.size() > 0) && (edgeCnt >= sb[0].due);
      checkVal("resp_valid", {31'd0, resp_valid}, {31'd0, expValid});
      if (expValid) begin
        checkVal("resp_out", {16'd0, resp_out}, {16'd0, sb[0].res});
        checkVal("resp_id", {31'd0, resp_id}, {31'd0, sb[0].id});
        if (resp_ready) sb.delete(0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int expOrder [4];
    int n;
    rst = 1'b1;
    resp_ready = 1'b1;

    $display("[TB] reset with both requesters valid, then grant order");
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{a: W'($urandom), b: W'($urandom), ctrl: 2'b00});
      q1.push_back('{a: W'($urandom), b: W'($urandom), ctrl: 2'b00});
    end
    doReset(3);
    drain(200, "grant_order");
`ifdef SCHED_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 0};
`else
    expOrder = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      checkVal("grant_order", (grantLog.size() > i) ? grantLog[i] : 99, expOrder[i]);
    end

    $display("[TB] directed ADD and MUL");
    q0.push_back('{a: 8'hF0, b: 8'h20, ctrl: 2'b00});
    drain(50, "add");
    q1.push_back('{a: 8'hFF, b: 8'hFF, ctrl: 2'b10});
    drain(50, "mul");

    $display("[TB] SUB with result held under backpressure");
    readyPct = 0;
    q0.push_back('{a: 8'h05, b: 8'h07, ctrl: 2'b01});
    q1.push_back('{a: 8'h11, b: 8'h22, ctrl: 2'b11});
    n = 0;
    while (!(mBusy && edgeCnt >= mDue) && n < 20) begin
      stepCycle();
      n++;
    end
    checkVal("sub_reached_done", {31'd0, n < 20}, 32'd1);
    repeat (3) stepCycle();
    readyPct = 100;
    drain(50, "sub");

    $display("[TB] reset in the middle of a MUL");
    q0.push_back('{a: 8'h12, b: 8'h34, ctrl: 2'b10});
    n = 0;
    while (!mBusy && n < 20) begin
      stepCycle();
      n++;
    end
    checkVal("mul_accepted", {31'd0, n < 20}, 32'd1);
    repeat (4) stepCycle();
    doReset(2);
    repeat (3) stepCycle();
    q0.push_back('{a: 8'h03, b: 8'h04, ctrl: 2'b10});
    drain(50, "mul_after_rst");

    $display("[TB] randomized traffic");
    readyPct = 70;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0)
        q0.push_back('{a: W'($urandom), b: W'($urandom), ctrl: 2'($urandom)});
      else
        q1.push_back('{a: W'($urandom), b: W'($urandom), ctrl: 2'($urandom)});
      repeat ($urandom_range(3)) stepCycle();
    end
    drain(3000, "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
